wb_seq_reader: RTL
==================

# wb_seq_reader

Wishbone master that reads a contiguous block of 32-bit words from a Wishbone slave memory, the `wb_bram` block or the SDRAM controller, and delivers them in order on a ready/valid stream. It sits directly upstream of the memory on the bus and feeds downstream consumers such as the video pixel path. It contains an internal first-word-fall-through FIFO and never issues a request when that FIFO has no room for the response.

## Interface
- `LEN_WIDTH`, default 16: width of the transfer length in words.
- `FIFO_DEPTH`, default 16: internal FIFO depth in words; must be a power of 2 and ≥ 2.
- `clk` in 1: system clock; same clock as `wb_m.clk`.
- `rst` in 1: reset, synchronous, active-high; same signal as `wb_m.rst`.
- `wb_m` wshb_if.master: Wishbone bus. Drives `adr`, `sel`, `stb`, `we`, `cyc`, `dat_ms`, `cti`, `bte`. Samples `dat_sm`, `ack`, `err`, `rty`.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `base_adr` in 32: byte address of the first word; latched on `start`; bits [1:0] are ignored and forced to 0.
- `len` in LEN_WIDTH: number of words to read; latched on `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a transfer ends, on success, error, or `len`=0.
- `error` out 1: sticky; set by `err`; cleared by the next accepted `start`.
- `out_data` out 32: FIFO head word.
- `out_valid` out 1: FIFO is not empty.
- `out_ready` in 1: the consumer pops the head when `out_valid && out_ready`.

## Operation
- Constant bus outputs: `we`=0, `sel`=4'hF, `cti`=3'b000 (classic cycle), `bte`=2'b00, `dat_ms`=0.
- `cyc` and `stb` are always equal. Both are registered and high only in REQ.
- State IDLE: on `start`:
  - If `len`=0: pulse `done` next cycle, stay in IDLE, clear `error`.
  - Otherwise: latch `cur_adr`={`base_adr`[31:2],2'b00} and `remaining`=`len`, clear `error`, then go to GAP.
- State GAP: bus idle for at least one cycle. Go to REQ when `fifo_count` < FIFO_DEPTH; otherwise stay in GAP.
- State REQ: `adr`=`cur_adr`. The cycle is held until `ack`, `err` or `rty` is sampled high.
  - `ack`: push `dat_sm` into the FIFO, `cur_adr` += 4 (modulo 2^32, wraps silently), `remaining` -= 1. If `remaining` was 1, go to IDLE and pulse `done`; otherwise go to GAP.
  - `err`: no push, set `error`, pulse `done`, go to IDLE.
  - `rty`: no push, address unchanged, go to GAP (the same word is retried).
  - Priority when several are high at once: `err` > `ack` > `rty`.
- `ack`, `err` and `rty` are ignored outside REQ. This absorbs the trailing ack from a registered-ack slave whose `stb` was still seen high.
- FIFO behaviour:
  - Single outstanding request plus the GAP space check guarantee no push when full.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - Pointers wrap modulo FIFO_DEPTH; `fifo_count` is log2(FIFO_DEPTH)+1 bits wide.
  - A pop when empty has no effect.
- `start` while `busy` is ignored.
- FIFO contents left over from a finished transfer remain poppable. A new transfer appends after them.
- Reset: at the first edge with `rst`=1, state becomes IDLE, the FIFO is emptied, `cyc`=`stb`=0, `adr`=0, and `busy`=`done`=`error`=`out_valid`=0. This applies even in the middle of a bus cycle.

## Timing
- `start` sampled at edge 0 → GAP after edge 0 → REQ (`cyc`/`stb` high) after edge 1, provided the FIFO has space.
- Slave with registered ack (ack one cycle after `stb`): `ack` is sampled at edge 3, so `out_valid`=1 after edge 3.
- Steady-state throughput: one word per 3 cycles (2 in REQ, 1 in GAP) when the consumer is always ready.
- `done` is high for exactly the cycle after the edge where the last `ack` (or `err`) is sampled. `busy` falls in that same cycle.
- `out_data` is valid in the same cycle as `out_valid`; there is no extra read latency.

## Test plan
- `base_adr`=0x100, `len`=4, memory[0x40..0x43]=A,B,C,D, `out_ready`=1: addresses 0x100, 0x104, 0x108, 0x10C in order; output sequence A,B,C,D; single `done` pulse; `error`=0; `stb` is low for at least one cycle between accesses.
- `len`=40, FIFO_DEPTH=16, `out_ready`=0: exactly 16 acks, then the master waits in GAP with `cyc`=0. Raising `out_ready` drains the FIFO, the transfer completes, and the data matches all 40 words.
- Slave asserts `err` on the 3rd access of `len`=8: 2 words pushed, `error`=1, one `done` pulse, `busy`=0. Next `start` clears `error`.
- `rty` on the 1st access, then `ack`: the same address is re-issued after one GAP cycle and the word is delivered once.
- `base_adr`=0xFFFFFFFC, `len`=2: addresses 0xFFFFFFFC then 0x00000000. Separately, `len`=0: a `done` pulse with no bus cycle. `start` pulsed while `busy`: ignored.
- `rst` asserted while `cyc`=1: `cyc`=0, `out_valid`=0 and `busy`=0 in the cycle after that edge; a new transfer after reset runs normally.

Source files
------------

// File: rtl/wb_seq_reader_if.sv
// Wishbone classic bus bundle shared by a master and a slave.
// clk/rst ride along so a bus-side slave model can use the same timing references.
interface wshb_if (
   input logic clk,
   input logic rst
);
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic [3:0]  sel;
   logic        stb;
   logic        we;
   logic        cyc;
   logic        ack;
   logic        err;
   logic        rty;
   logic [2:0]  cti;
   logic [1:0]  bte;

   modport master (
      output adr, dat_ms, sel, stb, we, cyc, cti, bte,
      input  dat_sm, ack, err, rty
   );

   modport slave (
      input  clk, rst, adr, dat_ms, sel, stb, we, cyc, cti, bte,
      output dat_sm, ack, err, rty
   );
endinterface

// File: rtl/wb_seq_reader.sv
// Wishbone block reader: fetches len words starting at base_adr, one request at a time,
// and streams them out of an internal first-word-fall-through FIFO.
module wb_seq_reader #(
   parameter int LEN_WIDTH  = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   wshb_if.master               wb_m,
   input  logic                 start,
   input  logic [31:0]          base_adr,
   input  logic [LEN_WIDTH-1:0] len,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [31:0]          out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           dbg_state
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GAP  = 2'd1,
      S_REQ  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [31:0]          cur_adr_q, cur_adr_d;
   logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
   logic                 cyc_q, cyc_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        fifo_count_q, fifo_count_d;
   logic [31:0]          mem_q [FIFO_DEPTH];
   logic                 push;
   logic                 pop;

   always_comb begin
      state_d     = state_q;
      cur_adr_d   = cur_adr_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      error_d     = error_q;
      push        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               error_d = 1'b0;
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  cur_adr_d   = base_adr & 32'hFFFF_FFFC;
                  remaining_d = len;
                  state_d     = S_GAP;
               end
            end
         end
         S_GAP: begin
            // Only one request is ever outstanding, so space now means space at ack time.
            if (fifo_count_q < CW'(FIFO_DEPTH)) state_d = S_REQ;
         end
         S_REQ: begin
            if (wb_m.err) begin
               error_d = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (wb_m.ack) begin
               push        = 1'b1;
               cur_adr_d   = cur_adr_q + 32'd4;
               remaining_d = remaining_q - LEN_WIDTH'(1);
               if (remaining_q == LEN_WIDTH'(1)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_GAP;
               end
            end else if (wb_m.rty) begin
               state_d = S_GAP;
            end
         end
         default: state_d = S_IDLE;
      endcase

      cyc_d = (state_d == S_REQ);

      pop      = (fifo_count_q != '0) && out_ready;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   fifo_count_d = fifo_count_q + CW'(1);
         2'b01:   fifo_count_d = fifo_count_q - CW'(1);
         default: fifo_count_d = fifo_count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cur_adr_q    <= '0;
         remaining_q  <= '0;
         cyc_q        <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_count_q <= '0;
      end else begin
         state_q      <= state_d;
         cur_adr_q    <= cur_adr_d;
         remaining_q  <= remaining_d;
         cyc_q        <= cyc_d;
         done_q       <= done_d;
         error_q      <= error_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_count_q <= fifo_count_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wb_m.dat_sm;
   end

   assign wb_m.adr    = cur_adr_q;
   assign wb_m.cyc    = cyc_q;
   assign wb_m.stb    = cyc_q;
   assign wb_m.we     = 1'b0;
   assign wb_m.sel    = 4'hF;
   assign wb_m.cti    = 3'b000;
   assign wb_m.bte    = 2'b00;
   assign wb_m.dat_ms = 32'd0;

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign error     = error_q;
   assign out_valid = (fifo_count_q != '0);
   assign out_data  = mem_q[rd_ptr_q];
   assign dbg_state = state_q;

endmodule
